router_fifo_pkt: RTL and testbench
==================================

// Module: router_fifo_pkt
// PURPOSE
//  Parametrised, packet-aware output FIFO for one router channel; next generation of the router FIFO.
//  Buffers header/payload/parity bytes from the register stage and returns them to the destination port on read_enb.
//  Tags each entry with the lfd (header) marker and tracks bytes left in the packet being read.
//  Adds overflow flag, pkt_remain and optional complete-packet count.
// PARAMETERS
//  WIDTH   8    data byte width; header = {len[WIDTH-1:2], addr[1:0]}, LEN_W = WIDTH-2
//  DEPTH   16   entries; power of 2, >= 4; localparam ADDR_W = $clog2(DEPTH)
// PORTS
//  clock       in   1          rising-edge clock; single clock domain
//  resetn      in   1          asynchronous active-low reset
//  soft_reset  in   1          synchronous flush (timeout from FSM)
//  write_enb   in   1          write request
//  read_enb    in   1          read request
//  lfd_state   in   1          current data_in is a header byte
//  data_in     in   WIDTH      byte to store
//  full        out  1          DEPTH entries held
//  empty       out  1          no entries held
//  data_out    out  WIDTH      registered read data
//  pkt_remain  out  LEN_W+1    bytes still to read in current packet (payload+parity)
//  overflow    out  1          1-cycle pulse: write_enb while full
//  pkt_count   out  ADDR_W+1   complete packets stored (see CONFIGURATION)
// BEHAVIOUR
//  Reset (resetn=0, async): pointers 0, full=0, empty=1, data_out=0, pkt_remain=0, overflow=0, pkt_count=0.
//    Memory contents are not cleared.
//  Storage: DEPTH x (WIDTH+1); bit WIDTH holds lfd_state sampled with the write.
//  Pointers: ADDR_W+1 bits incl. wrap bit.
//    empty = (wr_ptr == rd_ptr).
//    full  = MSBs differ, low bits equal.
//    Flags are combinational from the registered pointers.
//  Write: accepted iff write_enb && !full; wr_ptr++ (wraps DEPTH-1 -> 0).
//    write_enb && full: data dropped, pointer held, overflow=1 next cycle.
//  Read: accepted iff read_enb && !empty.
//    data_out <= mem[rd_ptr][WIDTH-1:0] on that edge (1-cycle latency); rd_ptr++.
//    read_enb && empty: no change; data_out holds.
//  Simultaneous read+write:
//    - neither full nor empty: both occur, occupancy unchanged.
//    - full: only the read occurs (write dropped, overflow pulses).
//    - empty: only the write occurs.
//  pkt_remain, on an accepted read:
//    - entry lfd=1: load {1'b0,len}+1.
//    - else, if nonzero: decrement.
//    - else: stay 0.
//    Reaches 0 after the parity byte is read.
//  When pkt_remain==0 and no read is accepted, data_out <= 0 (bus idle between packets).
//  soft_reset (sync) outranks read/write in the same cycle.
//    Clears pointers, pkt_remain, data_out, overflow and pkt_count; memory untouched.
//  resetn deassertion mid-packet: packet is lost; source FSM restarts on the next header.
// CONFIGURATION
//  ROUTER_FIFO_PKT_CNT_EN defined:
//    - Write-side counter wr_left (LEN_W+1 bits).
//    - Accepted header write loads len+1.
//    - Other accepted writes decrement wr_left.
//    - The decrement to 0 increments pkt_count.
//    - An accepted read that moves pkt_remain 1 -> 0 decrements pkt_count.
//    - Both in one cycle: net 0.
//    - Saturates at 0 and DEPTH.
//  Not defined: pkt_count tied to 0, no wr_left logic; all other behaviour identical.
// STRUCTURE
//  router_pkg: HDR_ADDR_LSB=0, HDR_ADDR_W=2, HDR_LEN_LSB=2, LFD_BIT index.
//    Also width function for LEN_W; shared with router FSM and register blocks.
//  Sub-module router_fifo_mem: DEPTH x (WIDTH+1) array.
//    Synchronous write port, combinational read port; no reset on the array.
//  Top holds pointers, flags, pkt_remain, data_out register and optional packet counter.
// TESTING
//  1 Reset: resetn=0 mid-cycle -> empty=1, full=0, data_out=0, pkt_remain=0 immediately.
//  2 Packet: header 8'h11 (len 4, addr 1) with lfd_state=1, 4 payload bytes, parity, then read 6:
//    - data_out = bytes in order, one cycle after each read.
//    - pkt_remain 5,4,3,2,1,0.
//    - data_out=0 the cycle after parity with read_enb=0.
//  3 Fill 16 writes -> full=1 after 16th.
//    - 17th write: overflow=1 for one cycle, data discarded.
//    - Read+write same cycle while full: read only.
//  4 Wrap: write 12, read 12, write 10, read 10 -> data intact across index 15->0; empty=1 at end.
//  5 soft_reset with read_enb=1 and write_enb=1 asserted, 5 entries held:
//    - empty=1, data_out=0, pkt_remain=0 next cycle.
//    - No write taken.
//  6 With ROUTER_FIFO_PKT_CNT_EN:
//    - Two packets written (len 2 and 3) -> pkt_count=2.
//    - Reading through first parity -> 1.
//    - Without macro: pkt_count stays 0.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - header field layout and width helpers shared by router FSM, register and FIFO blocks
package router_pkg;

  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_W   = 2;
  localparam int HDR_LEN_LSB  = 2;

  // Packet length field width for a given byte width
  function automatic int len_w(input int width);
    return width - HDR_LEN_LSB;
  endfunction

  // The lfd marker sits just above the data byte in each FIFO entry
  function automatic int lfd_bit(input int width);
    return width;
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// rtl/router_fifo_mem.sv - DEPTH x DW storage array, synchronous write, combinational read, no reset
module router_fifo_mem #(
  parameter int DW     = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo_pkt.sv
// rtl/router_fifo_pkt.sv - packet-aware router output FIFO with overflow flag and bytes-remaining tracking
// Optional complete-packet counter enabled by defining ROUTER_FIFO_PKT_CNT_EN.
module router_fifo_pkt
  import router_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int LEN_W  = len_w(WIDTH),
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [WIDTH-1:0]  data_in,
  output logic              full,
  output logic              empty,
  output logic [WIDTH-1:0]  data_out,
  output logic [LEN_W:0]    pkt_remain,
  output logic              overflow,
  output logic [ADDR_W:0]   pkt_count
);

  localparam int LFD = lfd_bit(WIDTH);
  localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);

  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [WIDTH:0]  rd_entry;
  logic            wr_ok, rd_ok, rd_lfd;
  logic [LEN_W:0]  rd_len_p1;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // A flush in the same cycle wins, so neither port moves
  assign wr_ok = write_enb && !full && !soft_reset;
  assign rd_ok = read_enb && !empty && !soft_reset;

  assign rd_lfd    = rd_entry[LFD];
  assign rd_len_p1 = {1'b0, rd_entry[WIDTH-1:HDR_LEN_LSB]} + REM_ONE;

  router_fifo_mem #(
    .DW     (WIDTH + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock (clock),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata ({lfd_state, data_in}),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_out   <= '0;
      pkt_remain <= '0;
      overflow   <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_out   <= '0;
      pkt_remain <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= write_enb && full;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_entry[WIDTH-1:0];
        if (rd_lfd)
          pkt_remain <= rd_len_p1;
        else if (pkt_remain != '0)
          pkt_remain <= pkt_remain - REM_ONE;
      end else if (pkt_remain == '0) begin
        // Idle the bus between packets
        data_out <= '0;
      end
    end
  end

`ifdef ROUTER_FIFO_PKT_CNT_EN
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  logic [LEN_W:0] wr_left;
  logic           pkt_in, pkt_out;

  assign pkt_in  = wr_ok && !lfd_state && (wr_left == REM_ONE);
  assign pkt_out = rd_ok && !rd_lfd && (pkt_remain == REM_ONE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_left   <= '0;
      pkt_count <= '0;
    end else if (soft_reset) begin
      wr_left   <= '0;
      pkt_count <= '0;
    end else begin
      if (wr_ok) begin
        if (lfd_state)
          wr_left <= {1'b0, data_in[WIDTH-1:HDR_LEN_LSB]} + REM_ONE;
        else if (wr_left != '0)
          wr_left <= wr_left - REM_ONE;
      end
      if (pkt_in && !pkt_out && pkt_count != CNT_MAX)
        pkt_count <= pkt_count + 1'b1;
      else if (pkt_out && !pkt_in && pkt_count != '0)
        pkt_count <= pkt_count - 1'b1;
    end
  end
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_router_fifo_pkt.sv
// tb/tb_router_fifo_pkt.sv - directed scoreboard bench for router_fifo_pkt
module tb_router_fifo_pkt;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

`ifdef ROUTER_FIFO_PKT_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = '0;
  logic       full, empty, overflow;
  logic [7:0] data_out;
  logic [6:0] pkt_remain;
  logic [4:0] pkt_count;

  int errors = 0;
  int checks = 0;
  logic [8:0] sb_q[$];
  int remain_m = 0;

  router_fifo_pkt #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .full       (full),
    .empty      (empty),
    .data_out   (data_out),
    .pkt_remain (pkt_remain),
    .overflow   (overflow),
    .pkt_count  (pkt_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_expect(input string tag);
    logic [8:0] e;
    e = sb_q.pop_front();
    if (e[8]) remain_m = int'(e[7:2]) + 1;
    else if (remain_m != 0) remain_m--;
    chk({tag, "_data"}, data_out, e[7:0]);
    chk({tag, "_remain"}, pkt_remain, remain_m);
  endtask

  task automatic do_write(input logic [7:0] d, input logic l);
    bit was_full;
    was_full = (sb_q.size() == DEPTH);
    write_enb = 1'b1; data_in = d; lfd_state = l;
    tick();
    write_enb = 1'b0; lfd_state = 1'b0;
    if (!was_full) sb_q.push_back({l, d});
    chk("wr_overflow", overflow, was_full);
    chk("wr_full", full, sb_q.size() == DEPTH);
    chk("wr_empty", empty, sb_q.size() == 0);
  endtask

  task automatic do_read();
    bit was_empty;
    was_empty = (sb_q.size() == 0);
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
    if (!was_empty) pop_expect("rd");
    chk("rd_empty", empty, sb_q.size() == 0);
  endtask

  task automatic do_rdwr(input logic [7:0] d, input logic l);
    bit was_full, was_empty;
    was_full  = (sb_q.size() == DEPTH);
    was_empty = (sb_q.size() == 0);
    read_enb = 1'b1; write_enb = 1'b1; data_in = d; lfd_state = l;
    tick();
    read_enb = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    if (!was_empty) pop_expect("rw");
    if (!was_full) sb_q.push_back({l, d});
    chk("rw_overflow", overflow, was_full);
    chk("rw_full", full, sb_q.size() == DEPTH);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_remain", pkt_remain, 7'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_pkt_count", pkt_count, 5'd0);
    tick();
    resetn = 1'b1;
    tick();

    // one packet: header 0x11 (len 4), 4 payload, parity
    do_write(8'h11, 1'b1);
    do_write(8'hA1, 1'b0);
    do_write(8'hB2, 1'b0);
    do_write(8'hC3, 1'b0);
    do_write(8'hD4, 1'b0);
    do_write(8'hE5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_read();
      chk("pkt_remain_seq", pkt_remain, 7'(5 - i));
    end
    tick();
    chk("idle_data_zero", data_out, 8'h00);

    // fill, overflow, read+write while full, drain
    for (int i = 0; i < DEPTH; i++) do_write(8'(8'h20 + i), 1'b0);
    chk("fill_full", full, 1'b1);
    do_write(8'hEE, 1'b0);
    tick();
    chk("overflow_one_cycle", overflow, 1'b0);
    do_rdwr(8'hDD, 1'b0);
    chk("rw_full_read_only", full, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) do_read();
    tick();
    chk("drain_empty", empty, 1'b1);

    // wrap across index 15 -> 0
    for (int i = 0; i < 12; i++) do_write(8'($urandom_range(1, 255)), 1'b0);
    for (int i = 0; i < 12; i++) do_read();
    for (int i = 0; i < 10; i++) do_write(8'($urandom_range(1, 255)), 1'b0);
    for (int i = 0; i < 10; i++) do_read();
    chk("wrap_empty", empty, 1'b1);
    tick();

    // soft_reset with read and write requests, 5 entries held
    do_write(8'h11, 1'b1);
    for (int i = 0; i < 5; i++) do_write(8'(8'h40 + i), 1'b0);
    do_read();
    soft_reset = 1'b1; read_enb = 1'b1; write_enb = 1'b1; data_in = 8'h77;
    tick();
    soft_reset = 1'b0; read_enb = 1'b0; write_enb = 1'b0;
    sb_q.delete();
    remain_m = 0;
    chk("srst_empty", empty, 1'b1);
    chk("srst_data", data_out, 8'h00);
    chk("srst_remain", pkt_remain, 7'd0);
    chk("srst_overflow", overflow, 1'b0);
    tick();
    chk("srst_no_write", empty, 1'b1);
    do_write(8'h5A, 1'b0);
    do_read();

    // packet counting: len 2 then len 3
    do_write(8'h08, 1'b1);
    do_write(8'h61, 1'b0);
    do_write(8'h62, 1'b0);
    do_write(8'h63, 1'b0);
    do_write(8'h0D, 1'b1);
    for (int i = 0; i < 4; i++) do_write(8'(8'h70 + i), 1'b0);
    chk("pkt_count_two", pkt_count, 5'(2 * CNT_ON));
    for (int i = 0; i < 4; i++) do_read();
    chk("pkt_count_one", pkt_count, 5'(CNT_ON));
    do_read();
    chk("pkt2_remain", pkt_remain, 7'd4);

    // asynchronous reset mid-cycle
    #2;
    resetn = 1'b0;
    #1;
    sb_q.delete();
    chk("arst_empty", empty, 1'b1);
    chk("arst_full", full, 1'b0);
    chk("arst_data", data_out, 8'h00);
    chk("arst_remain", pkt_remain, 7'd0);
    chk("arst_pkt_count", pkt_count, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
